// File: rtl/register_bank_writer_pkg.sv
// Shared types and width helpers for the register bank write sequencer.
// The abort input is only present when RBW_ABORT_EN is defined.
package register_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_DATA_W   = 8;

  function automatic int calc_addr_w(input int num_regs);
    return (num_regs < 2) ? 1 : $clog2(num_regs);
  endfunction

  function automatic int calc_len_w(input int num_regs);
    return $clog2(num_regs) + 1;
  endfunction

endpackage

// File: rtl/register_bank_writer_if.sv
// Request, data-beat and bank-side signals of the write sequencer.
// abort_in exists only when RBW_ABORT_EN is defined.
interface register_bank_writer_if
  import register_bank_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W
);
  localparam int ADDR_W = calc_addr_w(NUM_REGS);
  localparam int LEN_W  = calc_len_w(NUM_REGS);

  logic                req_valid_in;
  logic                req_ready_out;
  logic [ADDR_W-1:0]   req_addr_in;
  logic [LEN_W-1:0]    req_len_in;
  logic                wr_valid_in;
  logic                wr_ready_out;
  logic [DATA_W-1:0]   wr_data_in;
  logic [NUM_REGS-1:0] ce_out;
  logic [DATA_W-1:0]   d_out;
  logic                busy_out;
  logic                done_out;
  logic                err_out;
`ifdef RBW_ABORT_EN
  logic                abort_in;
`endif

  modport master (
`ifdef RBW_ABORT_EN
    output abort_in,
`endif
    output req_valid_in, req_addr_in, req_len_in, wr_valid_in, wr_data_in,
    input  req_ready_out, wr_ready_out, ce_out, d_out, busy_out, done_out, err_out
  );

  modport slave (
`ifdef RBW_ABORT_EN
    input  abort_in,
`endif
    input  req_valid_in, req_addr_in, req_len_in, wr_valid_in, wr_data_in,
    output req_ready_out, wr_ready_out, ce_out, d_out, busy_out, done_out, err_out
  );

endinterface

// File: rtl/register_bank_writer_onehot_decoder.sv
// Combinational address to one-hot enable decoder; the parent registers the result.
module onehot_decoder #(
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot[i] = (addr == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/register_bank_writer.sv
// Burst write sequencer driving one-hot clock enables and shared data into a register bank.
// Define RBW_ABORT_EN to add an abort input that ends a burst early.
//
// state | meaning
// IDLE  | accepting burst requests; malformed ones pulse err_out
// WRITE | accepting data beats, one registered ce per beat
// DONE  | one-cycle done_out pulse (final ce still visible), then IDLE
module register_bank_writer
  import register_bank_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W
) (
  input logic                   clk_in,
  input logic                   rst_n_in,
  register_bank_writer_if.slave bus
);

  localparam int ADDR_W = calc_addr_w(NUM_REGS);
  localparam int LEN_W  = calc_len_w(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(NUM_REGS);

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [LEN_W-1:0]    count;
  logic [NUM_REGS-1:0] ce_r;
  logic [NUM_REGS-1:0] addr_onehot;
  logic [DATA_W-1:0]   d_r;
  logic                done_r;
  logic                err_r;
  logic                abort_now;

`ifdef RBW_ABORT_EN
  assign abort_now = (state == WRITE) && bus.abort_in;
`else
  assign abort_now = 1'b0;
`endif

  onehot_decoder #(
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_dec (
    .addr  (addr),
    .onehot(addr_onehot)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state  <= IDLE;
      addr   <= '0;
      count  <= '0;
      ce_r   <= '0;
      d_r    <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      ce_r   <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid_in) begin
            if ((bus.req_len_in == '0) || (bus.req_len_in > MAX_LEN)) begin
              err_r <= 1'b1;
            end else begin
              addr  <= bus.req_addr_in;
              count <= bus.req_len_in;
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          // abort wins over a same-cycle beat: that beat is dropped
          if (abort_now) begin
            done_r <= 1'b1;
            err_r  <= 1'b1;
            state  <= DONE;
          end else if (bus.wr_valid_in) begin
            ce_r  <= addr_onehot;
            d_r   <= bus.wr_data_in;
            addr  <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
            count <= count - LEN_W'(1);
            if (count == LEN_W'(1)) begin
              done_r <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_out = rst_n_in && (state == IDLE);
  assign bus.wr_ready_out  = rst_n_in && (state == WRITE);
  assign bus.busy_out      = (state != IDLE);
  assign bus.ce_out        = ce_r;
  assign bus.d_out         = d_r;
  assign bus.done_out      = done_r;
  assign bus.err_out       = err_r;

endmodule

// File: tb/tb_register_bank_writer.sv
// Randomized scoreboard bench for register_bank_writer with a downstream bank model.
// Abort scenarios are exercised when RBW_ABORT_EN is defined.
module tb_register_bank_writer;

  localparam int N = 8;

  typedef struct packed {
    logic [7:0] ce;
    logic [7:0] d;
    logic       done;
    logic       err;
  } ev_t;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  int   checks     = 0;
  int   miscompares = 0;
  ev_t  exp_q[$];
  logic [7:0] bank [N];
  logic [7:0] exp_bank [N];
  bit         exp_written [N];
  bit         pat[$];

  register_bank_writer_if #(.NUM_REGS(N), .DATA_W(8)) bus ();

  register_bank_writer #(.NUM_REGS(N), .DATA_W(8)) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  // downstream bank: register i loads d_out whenever its ce is high
  always @(posedge clk_in) begin
    for (int i = 0; i < N; i++) if (bus.ce_out[i]) bank[i] <= bus.d_out;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ev_t mk_ev(input int idx, input logic [7:0] d, input bit done, input bit err);
    ev_t e;
    e.ce   = (idx < 0) ? 8'h00 : 8'(1 << idx);
    e.d    = d;
    e.done = done;
    e.err  = err;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // scoreboard monitor: pops one expected event per cycle with any output activity
  initial begin
    ev_t e;
    forever begin
      @(negedge clk_in);
      if (rst_n_in && (bus.ce_out != '0 || bus.done_out || bus.err_out)) begin
        if (exp_q.size() == 0) begin
          checks++;
          miscompares++;
          $display("FAIL unexpected_output: ce=%b done=%b err=%b, expected no activity",
                   bus.ce_out, bus.done_out, bus.err_out);
        end else begin
          e = exp_q.pop_front();
          chk("ce_out", bus.ce_out, e.ce);
          if (e.ce != 8'h00) chk("d_out", bus.d_out, e.d);
          chk("done_out", bus.done_out, e.done);
          chk("err_out", bus.err_out, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Issue a request; for legal lengths feed beats until len beats or stop_after beats.
  task automatic do_burst(input int a, input int l, input int stop_after,
                          input int gap_pct, input bit hold_req);
    bit v;
    int nb;
    int idx;
    logic [7:0] data;
    chk("req_ready_idle", bus.req_ready_out, 1);
    chk("busy_idle", bus.busy_out, 0);
    bus.req_valid_in = 1'b1;
    bus.req_addr_in  = 3'(a);
    bus.req_len_in   = 4'(l);
    tick();
    bus.req_valid_in = 1'b0;
    if (l < 1 || l > N) begin
      exp_q.push_back(mk_ev(-1, 8'h00, 1'b0, 1'b1));
      chk("req_ready_after_err", bus.req_ready_out, 1);
      chk("busy_after_err", bus.busy_out, 0);
      return;
    end
    chk("wr_ready_write", bus.wr_ready_out, 1);
    chk("req_ready_write", bus.req_ready_out, 0);
    nb = 0;
    while (nb < l && nb < stop_after) begin
      v = (pat.size() != 0) ? pat.pop_front() : ($urandom_range(0, 99) >= gap_pct);
      data = 8'($urandom);
      bus.wr_valid_in = v;
      bus.wr_data_in  = data;
      if (hold_req) begin
        bus.req_valid_in = 1'b1;
        bus.req_addr_in  = 3'($urandom);
        bus.req_len_in   = 4'($urandom);
      end
      if (v) begin
        idx = (a + nb) % N;
        exp_q.push_back(mk_ev(idx, data, nb == l - 1, 1'b0));
        exp_bank[idx]    = data;
        exp_written[idx] = 1'b1;
        nb++;
      end
      tick();
    end
    bus.req_valid_in = 1'b0;
    bus.wr_valid_in  = 1'b0;
    if (nb < l) return;
    // DONE cycle: beats offered here must be ignored
    bus.wr_valid_in = 1'($urandom_range(0, 1));
    chk("wr_ready_done", bus.wr_ready_out, 0);
    chk("req_ready_done", bus.req_ready_out, 0);
    chk("busy_done", bus.busy_out, 1);
    tick();
    bus.wr_valid_in = 1'b0;
  endtask

  task automatic check_bank(input string name);
    for (int i = 0; i < N; i++) if (exp_written[i]) chk(name, bank[i], exp_bank[i]);
  endtask

  initial begin
    bus.req_valid_in = 1'b0;
    bus.req_addr_in  = '0;
    bus.req_len_in   = '0;
    bus.wr_valid_in  = 1'b0;
    bus.wr_data_in   = '0;
`ifdef RBW_ABORT_EN
    bus.abort_in     = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      exp_bank[i]    = 8'h00;
      exp_written[i] = 1'b0;
    end
    repeat (3) @(posedge clk_in);
    #1;
    chk("req_ready_in_reset", bus.req_ready_out, 0);
    chk("wr_ready_in_reset", bus.wr_ready_out, 0);
    #3 rst_n_in = 1'b1;
    tick();
    chk("reset_ce", bus.ce_out, 0);
    chk("reset_d", bus.d_out, 0);
    chk("reset_done", bus.done_out, 0);
    chk("reset_err", bus.err_out, 0);
    chk("reset_busy", bus.busy_out, 0);

    // single write
    pat = '{1'b1};
    bus.wr_data_in = 8'hA5;
    do_burst(3, 1, 99, 0, 1'b0);
    tick();
    chk("single_reg3", bank[3], 8'h00 | exp_bank[3]);

    // wrapping burst, back-to-back beats
    do_burst(6, 4, 99, 0, 1'b0);
    tick();

    // malformed requests
    do_burst(1, 0, 99, 0, 1'b0);
    do_burst(5, 9, 99, 0, 1'b0);
    tick();

    // gaps plus a request held high through WRITE
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_burst(0, 3, 99, 0, 1'b1);
    tick();
    do_burst(4, 4, 99, 0, 1'b0);
    tick();
    check_bank("bank_pre_reset");

    // reset mid-burst: beats 1-2 land, third beat is lost to reset
    do_burst(2, 5, 2, 0, 1'b0);
    bus.wr_valid_in = 1'b1;
    bus.wr_data_in  = 8'($urandom);
    @(posedge clk_in);
    #1 rst_n_in = 1'b0;
    #1;
    chk("ce_cleared_by_reset", bus.ce_out, 0);
    chk("busy_in_reset", bus.busy_out, 0);
    bus.wr_valid_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tick();
    chk("req_ready_after_reset", bus.req_ready_out, 1);
    check_bank("bank_after_reset");

`ifdef RBW_ABORT_EN
    do_burst(5, 4, 1, 0, 1'b0);
    bus.wr_valid_in = 1'b1;
    bus.wr_data_in  = 8'h5A;
    bus.abort_in    = 1'b1;
    exp_q.push_back(mk_ev(-1, 8'h00, 1'b1, 1'b1));
    tick();
    bus.abort_in    = 1'b0;
    bus.wr_valid_in = 1'b0;
    chk("busy_abort_done", bus.busy_out, 1);
    tick();
    chk("req_ready_after_abort", bus.req_ready_out, 1);
    bus.abort_in = 1'b1;
    tick();
    bus.abort_in = 1'b0;
`endif

    // randomized bursts with idle-cycle noise on the beat input
    for (int n = 0; n < 40; n++) begin
      do_burst(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 10)), 99, 30,
               1'($urandom_range(0, 1)));
      bus.wr_valid_in = 1'($urandom_range(0, 1));
      tick();
      bus.wr_valid_in = 1'b0;
    end

    repeat (3) tick();
    check_bank("bank_final");
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
    $finish;
  end

endmodule
